// File: rtl/mmio_uart_pkg.sv
// Shared register map, STATUS bit positions and serializer states for the
// memory-mapped UART transmitter.
package mmio_uart_pkg;

    localparam logic [3:0] TXDATA_OFF  = 4'h0;
    localparam logic [3:0] STATUS_OFF  = 4'h4;
    localparam logic [3:0] BAUDDIV_OFF = 4'h8;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_IE      = 4;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART serializer. A push while full is still accepted
// when a pop happens in the same cycle, because that pop frees a slot.
module uart_tx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] MAX_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == MAX_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: TXDATA/STATUS/BAUDDIV registers, TX FIFO and an 8N1
// serializer. Define MMIO_UART_IRQ_EN to enable the TX-empty interrupt.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int DEFAULT_DIV = 434,
    parameter int DIV_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        uart_tx,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t        state;
    tx_state_t        state_n;
    logic             wr_acc;
    logic             rd_acc;
    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             overflow;
    logic             ie_bit;
    logic [DIV_W-1:0] baud_div;
    logic [DIV_W-1:0] cur_div;
    logic [DIV_W-1:0] bit_cnt;
    logic             bit_done;
    logic             cnt_clr;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             line_n;
    logic [31:0]      status;
    logic [31:0]      rd_val;
    logic             unused_wdata;

    assign wr_acc       = sel & we;
    assign rd_acc       = sel & ~we;
    assign fifo_push    = wr_acc && (addr == TXDATA_OFF);
    assign unused_wdata = ^wdata;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Overflow is sticky; only a dropped byte sets it, only software clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end else if (wr_acc && (addr == STATUS_OFF) && wdata[ST_OVF]) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_div <= DIV_W'(DEFAULT_DIV);
        end else if (wr_acc && (addr == BAUDDIV_OFF)) begin
            baud_div <= (wdata[DIV_W-1:0] == '0) ? DIV_W'(1) : wdata[DIV_W-1:0];
        end
    end

`ifdef MMIO_UART_IRQ_EN
    logic tx_empty_ie;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_empty_ie <= 1'b0;
        end else if (wr_acc && (addr == STATUS_OFF)) begin
            tx_empty_ie <= wdata[ST_IE];
        end
    end

    assign ie_bit = tx_empty_ie;
    assign irq    = tx_empty_ie & fifo_empty & (state == IDLE);
`else
    assign ie_bit = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        status                     = '0;
        status[ST_FULL]            = fifo_full;
        status[ST_EMPTY]           = fifo_empty;
        status[ST_BUSY]            = (state != IDLE);
        status[ST_OVF]             = overflow;
        status[ST_IE]              = ie_bit;
        status[ST_CNT_LSB +: 8]    = 8'(fifo_count);
    end

    always_comb begin
        rd_val = '0;
        case (addr)
            STATUS_OFF:  rd_val = status;
            BAUDDIV_OFF: rd_val = 32'(baud_div);
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (rd_acc) begin
            rdata <= rd_val;
        end
    end

    // The divider is sampled into cur_div at every bit boundary, so a BAUDDIV
    // write never stretches or shortens a bit already in flight.
    assign bit_done = (bit_cnt == cur_div - DIV_W'(1));
    assign cnt_clr  = (state == IDLE) | bit_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        fifo_pop = 1'b0;
        line_n   = 1'b1;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_n  = START;
                end
            end
            START: begin
                line_n = 1'b0;
                if (bit_done) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                line_n = shreg[0];
                if (bit_done && (bit_idx == 3'd7)) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_n  = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // uart_tx is registered from line_n, so the line trails the state by one
    // clock but can never glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            cur_div <= DIV_W'(DEFAULT_DIV);
            bit_idx <= '0;
            shreg   <= '0;
            uart_tx <= 1'b1;
        end else begin
            uart_tx <= line_n;
            if (cnt_clr) begin
                bit_cnt <= '0;
                cur_div <= baud_div;
            end else begin
                bit_cnt <= bit_cnt + DIV_W'(1);
            end
            if (fifo_pop) begin
                shreg <= fifo_dout;
            end else if ((state == DATA) && bit_done) begin
                shreg <= {1'b0, shreg[7:1]};
            end
            if (state == START) begin
                bit_idx <= '0;
            end else if ((state == DATA) && bit_done) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a cycle-level reference model feeds a byte
// scoreboard that a line-decoding monitor drains frame by frame.
module tb_mmio_uart_tx;

    localparam int DEPTH   = 16;
    localparam int DEF_DIV = 434;
`ifdef MMIO_UART_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        uart_tx;
    logic        irq;

    int          checks = 0;
    int          errors = 0;

    int unsigned cyc = 0;
    int          m_count;
    int          m_div;
    bit          m_ovf;
    bit          m_ie;
    bit          m_active;
    int unsigned m_end;
    logic [31:0] m_rdata;
    logic [7:0]  exp_q [$];
    int          frames_seen = 0;
    bit          check_gap = 1'b0;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (DEF_DIV),
        .DIV_W       (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .uart_tx (uart_tx),
        .irq     (irq)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {16'h0, 8'(m_count), 3'b0, m_ie, m_ovf, m_active, (m_count == 0), (m_count == DEPTH)};
    endfunction

    task automatic model_reset();
        m_count  = 0;
        m_div    = DEF_DIV;
        m_ovf    = 1'b0;
        m_ie     = 1'b0;
        m_active = 1'b0;
        m_rdata  = '0;
        exp_q.delete();
    endtask

    // Frame-level reference: a frame lasts 10*BAUDDIV clocks from the pop that
    // starts it, and the next byte is taken as soon as the previous one ends.
    task automatic model_step();
        bit pop;
        pop = 1'b0;
        if (sel && !we) begin
            if (addr == 4'h4)      m_rdata = m_status();
            else if (addr == 4'h8) m_rdata = 32'(m_div);
            else                   m_rdata = '0;
        end
        if (m_active && (cyc == m_end)) m_active = 1'b0;
        if (!m_active && (m_count > 0)) begin
            pop      = 1'b1;
            m_active = 1'b1;
            m_end    = cyc + 10 * m_div;
        end
        if (sel && we) begin
            if (addr == 4'h0) begin
                if ((m_count < DEPTH) || pop) begin
                    exp_q.push_back(wdata[7:0]);
                    m_count++;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (addr == 4'h4) begin
                if (wdata[3]) m_ovf = 1'b0;
                if (IRQ_ON) m_ie = wdata[4];
            end else if (addr == 4'h8) begin
                m_div = (wdata[15:0] == 16'h0) ? 1 : int'(wdata[15:0]);
            end
        end
        if (pop) m_count--;
    endtask

    initial begin : model_proc
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) model_step();
        end
    end

    // Decodes each frame off the line, checks every bit holds for exactly one
    // bit time, and compares the byte against the scoreboard.
    initial begin : monitor
        logic       prev;
        logic [9:0] bv;
        logic [7:0] exp_b;
        bit         glitch;
        bit         aborted;
        bit         more;
        int         d;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev = 1'b1;
            end else if ((prev === 1'b1) && (uart_tx === 1'b0)) begin
                more = 1'b1;
                while (more) begin
                    more    = 1'b0;
                    d       = m_div;
                    bv      = '1;
                    bv[0]   = uart_tx;
                    glitch  = 1'b0;
                    aborted = 1'b0;
                    for (int c = 1; c < 10 * d; c++) begin
                        @(negedge clk);
                        if (!rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if ((c % d) == 0) bv[c / d] = uart_tx;
                        else if (uart_tx !== bv[c / d]) glitch = 1'b1;
                    end
                    if (aborted) begin
                        prev = 1'b1;
                    end else begin
                        frames_seen++;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpected_frame: got 0x%0h expected no frame", bv[8:1]);
                        end else begin
                            exp_b = exp_q.pop_front();
                            check_output("frame_data", 32'(bv[8:1]), 32'(exp_b));
                        end
                        check_output("frame_shape", {30'h0, glitch, bv[9]}, 32'h1);
                        prev = bv[9];
                        if (check_gap && (exp_q.size() > 0)) begin
                            @(negedge clk);
                            check_output("frame_gap", 32'(uart_tx), 32'h0);
                            if (rst && (uart_tx === 1'b0)) more = 1'b1;
                            else prev = uart_tx;
                        end
                    end
                end
            end else begin
                prev = uart_tx;
            end
        end
    end

    initial begin : irq_check
        forever begin
            @(negedge clk);
            if (rst) check_output("irq_level", 32'(irq), 32'(m_ie && (m_count == 0) && !m_active));
        end
    end

    task automatic mmio_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        sel = 1'b0;
        we  = 1'b0;
    endtask

    task automatic mmio_read(input logic [3:0] a, input string name);
        @(negedge clk);
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        @(posedge clk);
        #1;
        sel = 1'b0;
        check_output(name, rdata, m_rdata);
    endtask

    task automatic wait_cycle(input int unsigned target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (!((m_count == 0) && !m_active && (exp_q.size() == 0)) && (n < budget)) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output(name, 32'(exp_q.size()), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check_output({name, "_line_idle"}, 32'(uart_tx), 32'h1);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int unsigned n;
        int          r;
        int          frames_before;

        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        check_output("reset_uart_tx", 32'(uart_tx), 32'h1);
        check_output("reset_irq", 32'(irq), 32'h0);
        check_output("reset_rdata", rdata, 32'h0);
        mmio_read(4'h4, "status_reset");
        check_output("status_reset_value", rdata, 32'h2);
        mmio_read(4'h8, "bauddiv_reset");
        check_output("bauddiv_reset_value", rdata, 32'd434);

        mmio_write(4'h8, 32'd4);
        mmio_write(4'h0, 32'hA5);
        n = cyc;
        check_output("latency_edge_n", 32'(uart_tx), 32'h1);
        wait_cycle(n + 1);
        check_output("latency_edge_n1", 32'(uart_tx), 32'h1);
        wait_cycle(n + 2);
        check_output("latency_edge_n2", 32'(uart_tx), 32'h0);
        wait_cycle(n + 40);
        mmio_read(4'h4, "status_busy_last");
        check_output("busy_last_cycle", 32'(rdata[2]), 32'h1);
        mmio_read(4'h4, "status_busy_clear");
        check_output("busy_cleared", 32'(rdata[2]), 32'h0);
        wait_idle(200, "drain_a5");

        mmio_write(4'h8, 32'd2);
        check_gap = 1'b1;
        for (int i = 0; i < 18; i++) mmio_write(4'h0, 32'(i));
        mmio_read(4'h4, "status_overflow");
        check_output("overflow_set", 32'(rdata[3]), 32'h1);
        mmio_write(4'h4, 32'h8);
        mmio_read(4'h4, "status_overflow_clr");
        check_output("overflow_cleared", 32'(rdata[3]), 32'h0);
        wait_idle(2000, "drain_burst");
        check_gap = 1'b0;

        mmio_write(4'h8, 32'h0);
        mmio_read(4'h8, "bauddiv_zero");
        check_output("bauddiv_zero_value", rdata, 32'h1);
        mmio_write(4'h0, 32'h3C);
        n = cyc;
        wait_cycle(n + 10);
        mmio_read(4'h4, "status_div1_busy");
        check_output("div1_busy_last", 32'(rdata[2]), 32'h1);
        mmio_read(4'h4, "status_div1_idle");
        check_output("div1_busy_cleared", 32'(rdata[2]), 32'h0);
        wait_idle(200, "drain_div1");

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                mmio_write(4'h0, $urandom);
            end else if (r == 5) begin
                mmio_read(4'h4, "rand_status");
            end else if (r == 6) begin
                if ((m_count == 0) && !m_active) mmio_write(4'h8, ($urandom & 32'hFFFF0000) | 32'($urandom_range(0, 5)));
                else @(posedge clk);
            end else if (r == 7) begin
                mmio_write(4'h4, $urandom & 32'h18);
            end else if (r == 8) begin
                mmio_read(4'($urandom_range(0, 15)), "rand_read");
            end else begin
                mmio_write(4'($urandom_range(9, 15)), $urandom);
            end
        end
        wait_idle(20000, "drain_random");

        mmio_write(4'h8, 32'd3);
        mmio_write(4'h4, 32'h10);
        @(posedge clk);
        #1;
        check_output("irq_enabled_idle", 32'(irq), 32'(IRQ_ON));
        mmio_write(4'h0, 32'h5A);
        repeat (5) @(posedge clk);
        #1;
        check_output("irq_during_frame", 32'(irq), 32'h0);
        wait_idle(200, "drain_irq");
        check_output("irq_after_frame", 32'(irq), 32'(IRQ_ON));
        mmio_write(4'h4, 32'h0);

        mmio_write(4'h8, 32'd4);
        mmio_write(4'h0, 32'h00);
        n = cyc;
        wait_cycle(n + 20);
        check_output("mid_data_low", 32'(uart_tx), 32'h0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_output("reset_abort_line", 32'(uart_tx), 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        frames_before = frames_seen;
        mmio_read(4'h4, "status_after_reset");
        check_output("status_after_reset_value", rdata, 32'h2);
        repeat (60) @(posedge clk);
        #1;
        check_output("no_frame_after_reset", 32'(frames_seen), 32'(frames_before));
        check_output("line_high_after_reset", 32'(uart_tx), 32'h1);

        check_output("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
